// File: rtl/fetch_npc_gen_if.sv
// Bundle between the IF-stage fetch control and its neighbours: PC register,
// hazard/EX inputs, instruction memory and the IF/ID pipeline register.
interface fetch_npc_gen_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16
);
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    npc;
    logic               stall;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic               if_id_valid;
    logic [PC_W-1:0]    if_id_pc;
    logic [PC_W-1:0]    if_id_npc;
    logic [INSTR_W-1:0] if_id_instr;

    // Handshake: imem_req high means the fetch unit wants the word at
    // imem_addr; a response is taken only in a cycle where imem_req and
    // imem_ready are both high, and imem_rdata is valid only in that cycle.
    modport master (
        input  pc, stall, branch_taken, branch_target, imem_ready, imem_rdata,
        output npc, imem_req, imem_addr,
        output if_id_valid, if_id_pc, if_id_npc, if_id_instr
    );

    modport slave (
        output pc, stall, branch_taken, branch_target, imem_ready, imem_rdata,
        input  npc, imem_req, imem_addr,
        input  if_id_valid, if_id_pc, if_id_npc, if_id_instr
    );
endinterface

// File: rtl/fetch_npc_gen.sv
// IF-stage fetch control: next-PC selection, imem request handshake, IF/ID
// register fill and a one-entry hold buffer for words that arrive under stall.
module fetch_npc_gen #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter int              PC_INC   = 1,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    fetch_npc_gen_if.master    bus,
    output logic               dbg_state
);
    typedef enum logic {S_REQ = 1'b0, S_HOLD = 1'b1} state_t;

    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    npcf_q, npcf_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    hold_pc_q, hold_pc_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    hold_pc_inc;
    logic [PC_W-1:0]    npc_sel;

    // Wraps modulo 2^PC_W by construction of the result width.
    assign pc_inc      = bus.pc + PC_W'(PC_INC);
    assign hold_pc_inc = hold_pc_q + PC_W'(PC_INC);

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        pc_d         = pc_q;
        npcf_d       = npcf_q;
        instr_d      = instr_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        npc_sel      = bus.pc;

        case (state_q)
            S_REQ: begin
                if (bus.branch_taken) begin
                    npc_sel = bus.branch_target;
                    valid_d = 1'b0;
                end else if (bus.imem_ready && !bus.stall) begin
                    valid_d = 1'b1;
                    pc_d    = bus.pc;
                    npcf_d  = pc_inc;
                    instr_d = bus.imem_rdata;
                    npc_sel = pc_inc;
                end else if (bus.imem_ready) begin
                    hold_pc_d    = bus.pc;
                    hold_instr_d = bus.imem_rdata;
                    state_d      = S_HOLD;
                end else if (!bus.stall) begin
                    valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (bus.branch_taken) begin
                    npc_sel      = bus.branch_target;
                    valid_d      = 1'b0;
                    hold_pc_d    = '0;
                    hold_instr_d = '0;
                    state_d      = S_REQ;
                end else if (!bus.stall) begin
                    valid_d = 1'b1;
                    pc_d    = hold_pc_q;
                    npcf_d  = hold_pc_inc;
                    instr_d = hold_instr_q;
                    npc_sel = pc_inc;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            valid_q      <= 1'b0;
            pc_q         <= '0;
            npcf_q       <= '0;
            instr_q      <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            npcf_q       <= npcf_d;
            instr_q      <= instr_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    assign bus.npc         = reset ? RESET_PC : npc_sel;
    assign bus.imem_req    = (state_q == S_REQ) && !reset;
    assign bus.imem_addr   = bus.pc;
    assign bus.if_id_valid = valid_q;
    assign bus.if_id_pc    = pc_q;
    assign bus.if_id_npc   = npcf_q;
    assign bus.if_id_instr = instr_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_fetch_npc_gen.sv
// Directed, table-driven check of fetch_npc_gen: each record drives one cycle
// of inputs, then checks the combinational outputs and the post-edge IF/ID state.
module tb_fetch_npc_gen;
    logic clk;
    logic reset;
    logic dbg_state;

    fetch_npc_gen_if #(.PC_W(16), .INSTR_W(16)) bus ();

    fetch_npc_gen #(.PC_W(16), .INSTR_W(16), .PC_INC(1), .RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic [15:0] pc;
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        rdy;
        logic [15:0] rdata;
        logic [15:0] e_npc;
        logic        e_req;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_ifnpc;
        logic [15:0] e_instr;
        logic        e_hold;
    } vec_t;

    vec_t vecs[$];
    logic [48:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(
        input logic rst, input logic [15:0] pc, input logic stall, input logic br,
        input logic [15:0] tgt, input logic rdy, input logic [15:0] rdata,
        input logic [15:0] e_npc, input logic e_req, input logic e_valid,
        input logic [15:0] e_pc, input logic [15:0] e_ifnpc,
        input logic [15:0] e_instr, input logic e_hold);
        vec_t v;
        v.rst = rst; v.pc = pc; v.stall = stall; v.br = br; v.tgt = tgt;
        v.rdy = rdy; v.rdata = rdata; v.e_npc = e_npc; v.e_req = e_req;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_ifnpc = e_ifnpc;
        v.e_instr = e_instr; v.e_hold = e_hold;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    // driver: one cycle per record
    task automatic apply(input vec_t v, input int idx);
        logic [48:0] e;
        @(negedge clk);
        reset             = v.rst;
        bus.pc            = v.pc;
        bus.stall         = v.stall;
        bus.branch_taken  = v.br;
        bus.branch_target = v.tgt;
        bus.imem_ready    = v.rdy;
        bus.imem_rdata    = v.rdata;
        #1;
        chk("npc", idx, {16'h0, bus.npc}, {16'h0, v.e_npc});
        chk("imem_req", idx, {31'h0, bus.imem_req}, {31'h0, v.e_req});
        chk("imem_addr", idx, {16'h0, bus.imem_addr}, {16'h0, v.pc});
        exp_q.push_back({v.e_valid, v.e_pc, v.e_ifnpc, v.e_instr});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("if_id_valid", idx, {31'h0, bus.if_id_valid}, {31'h0, e[48]});
        chk("if_id_pc", idx, {16'h0, bus.if_id_pc}, {16'h0, e[47:32]});
        chk("if_id_npc", idx, {16'h0, bus.if_id_npc}, {16'h0, e[31:16]});
        chk("if_id_instr", idx, {16'h0, bus.if_id_instr}, {16'h0, e[15:0]});
        chk("state", idx, {31'h0, dbg_state}, {31'h0, v.e_hold});
    endtask

    initial begin
        reset = 1'b1;
        bus.pc = '0; bus.stall = 1'b0; bus.branch_taken = 1'b0;
        bus.branch_target = '0; bus.imem_ready = 1'b0; bus.imem_rdata = '0;

        //              rst pc       st br tgt      rdy rdata     npc      req val ifpc     ifnpc    instr    hold
        // reset for three cycles: npc forced to RESET_PC, no request
        vecs.push_back(mk(1, 16'h0007, 0, 0, 16'h0000, 1, 16'h1234, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(1, 16'h0000, 0, 0, 16'h0000, 1, 16'hA5A5, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(1, 16'h0000, 0, 0, 16'h0000, 1, 16'hA5A5, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0));
        // zero-wait stream, rdata = pc ^ A5A5
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 1, 16'hA5A5, 16'h0001, 1, 1, 16'h0000, 16'h0001, 16'hA5A5, 0));
        vecs.push_back(mk(0, 16'h0001, 0, 0, 16'h0000, 1, 16'hA5A4, 16'h0002, 1, 1, 16'h0001, 16'h0002, 16'hA5A4, 0));
        vecs.push_back(mk(0, 16'h0002, 0, 0, 16'h0000, 1, 16'hA5A7, 16'h0003, 1, 1, 16'h0002, 16'h0003, 16'hA5A7, 0));
        vecs.push_back(mk(0, 16'h0003, 0, 0, 16'h0000, 1, 16'hA5A6, 16'h0004, 1, 1, 16'h0003, 16'h0004, 16'hA5A6, 0));
        vecs.push_back(mk(0, 16'h0004, 0, 0, 16'h0000, 1, 16'hA5A1, 16'h0005, 1, 1, 16'h0004, 16'h0005, 16'hA5A1, 0));
        // memory wait at pc=5: bubbles, then delivery
        vecs.push_back(mk(0, 16'h0005, 0, 0, 16'h0000, 0, 16'h1234, 16'h0005, 1, 0, 16'h0004, 16'h0005, 16'hA5A1, 0));
        vecs.push_back(mk(0, 16'h0005, 0, 0, 16'h0000, 0, 16'h1234, 16'h0005, 1, 0, 16'h0004, 16'h0005, 16'hA5A1, 0));
        vecs.push_back(mk(0, 16'h0005, 0, 0, 16'h0000, 1, 16'hA5A0, 16'h0006, 1, 1, 16'h0005, 16'h0006, 16'hA5A0, 0));
        // wait under stall keeps IF/ID valid
        vecs.push_back(mk(0, 16'h0006, 1, 0, 16'h0000, 0, 16'h1234, 16'h0006, 1, 1, 16'h0005, 16'h0006, 16'hA5A0, 0));
        // pc=8 arrives under stall -> HOLD for 3 cycles, then release
        vecs.push_back(mk(0, 16'h0008, 1, 0, 16'h0000, 1, 16'hA5AD, 16'h0008, 1, 1, 16'h0005, 16'h0006, 16'hA5A0, 1));
        vecs.push_back(mk(0, 16'h0008, 1, 0, 16'h0000, 1, 16'hBEEF, 16'h0008, 0, 1, 16'h0005, 16'h0006, 16'hA5A0, 1));
        vecs.push_back(mk(0, 16'h0008, 1, 0, 16'h0000, 1, 16'hBEEF, 16'h0008, 0, 1, 16'h0005, 16'h0006, 16'hA5A0, 1));
        vecs.push_back(mk(0, 16'h0008, 0, 0, 16'h0000, 1, 16'hBEEF, 16'h0009, 0, 1, 16'h0008, 16'h0009, 16'hA5AD, 0));
        // branch beats stall and ready
        vecs.push_back(mk(0, 16'h0009, 1, 1, 16'h0040, 1, 16'hA5AC, 16'h0040, 1, 0, 16'h0008, 16'h0009, 16'hA5AD, 0));
        // branch out of HOLD drops the buffered word
        vecs.push_back(mk(0, 16'h0040, 1, 0, 16'h0000, 1, 16'h1111, 16'h0040, 1, 0, 16'h0008, 16'h0009, 16'hA5AD, 1));
        vecs.push_back(mk(0, 16'h0040, 1, 1, 16'h0080, 1, 16'h1111, 16'h0080, 0, 0, 16'h0008, 16'h0009, 16'hA5AD, 0));
        vecs.push_back(mk(0, 16'h0080, 0, 0, 16'h0000, 1, 16'h2222, 16'h0081, 1, 1, 16'h0080, 16'h0081, 16'h2222, 0));
        // wrap at top of address space
        vecs.push_back(mk(0, 16'hFFFF, 0, 0, 16'h0000, 1, 16'h5A5A, 16'h0000, 1, 1, 16'hFFFF, 16'h0000, 16'h5A5A, 0));
        // reset while in HOLD
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h3333, 16'h0000, 1, 1, 16'hFFFF, 16'h0000, 16'h5A5A, 1));
        vecs.push_back(mk(1, 16'h0000, 1, 0, 16'h0000, 1, 16'h9999, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h4444, 16'h0001, 1, 1, 16'h0000, 16'h0001, 16'h4444, 0));

        foreach (vecs[i]) apply(vecs[i], i);

        // hand sequence: reset during a memory wait leaves no residual state
        apply(mk(0, 16'h0020, 0, 0, 16'h0000, 0, 16'h7777, 16'h0020, 1, 0, 16'h0000, 16'h0001, 16'h4444, 0), 100);
        apply(mk(1, 16'h0020, 0, 0, 16'h0000, 1, 16'h7777, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0), 101);
        apply(mk(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h5555, 16'h0001, 1, 1, 16'h0000, 16'h0001, 16'h5555, 0), 102);

        // hand sequence: HOLD ignores imem_ready toggling, releases the buffered word
        apply(mk(0, 16'h0010, 1, 0, 16'h0000, 1, 16'hCAFE, 16'h0010, 1, 1, 16'h0000, 16'h0001, 16'h5555, 1), 110);
        apply(mk(0, 16'h0010, 1, 0, 16'h0000, 0, 16'h0BAD, 16'h0010, 0, 1, 16'h0000, 16'h0001, 16'h5555, 1), 111);
        apply(mk(0, 16'h0010, 0, 0, 16'h0000, 0, 16'h0BAD, 16'h0011, 0, 1, 16'h0010, 16'h0011, 16'hCAFE, 0), 112);
        apply(mk(0, 16'h0011, 0, 0, 16'h0000, 1, 16'hD00D, 16'h0012, 1, 1, 16'h0011, 16'h0012, 16'hD00D, 0), 113);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
